ddr_line_mirror_buf: RTL and testbench
======================================

// Module: ddr_line_mirror_buf
// PURPOSE
//  Single-clock ping-pong line buffer between the DDR read path and the HDMI pixel path.
//  Accepts wide DDR beats, stores two full lines, and replays each line one pixel per rd_en.
//  Replay is in forward or horizontally mirrored order, with an optional programmable blanking window.
//  Generalises the earlier FIFO/RAM pair: beat, pixel and line sizes are parametrised, and it adds
//  flow control, frame-aligned mode switching and error flags.
// PARAMETERS
//  DQ_WIDTH   32    DDR DQ width; beat width BW = DQ_WIDTH*8 bits
//  PIX_WIDTH  16    pixel width (RGB565); PPB = BW/PIX_WIDTH pixels per beat, must be an integer
//  H_WIDTH    1280  pixels per line; must be a multiple of PPB (BPL = H_WIDTH/PPB beats/line)
//  H_HEIGHT   720   lines per frame
//  BLANK_X0   960   first blanked column (inclusive)
//  BLANK_Y0   180   first blanked row (inclusive)
// PORTS
//  clk               in   1          single clock for all logic
//  rst               in   1          asynchronous reset, active-high
//  frame_start       in   1          1-cycle pulse at start of each output frame
//  ctrl_command_in   in   4          command class
//  value_command_in  in   4          command value
//  command_flag      in   1          command valid strobe
//  buf_wr_en         in   1          write one beat
//  buf_wr_data       in   BW         beat data; pixel k = bits [k*PIX_WIDTH +: PIX_WIDTH]
//  buf_wr_ready      out  1          current write bank is free
//  rd_en             in   1          request one output pixel
//  de_o              out  1          pixel valid, rd_en delayed 1 cycle
//  rgb_out           out  PIX_WIDTH  output pixel
//  row_count         out  11         current output row, 0..H_HEIGHT-1
//  frame_instruct    out  1          0 on frames 1-2, 1 on frames 3-4 of a 4-frame cycle
//  ovf_err, unf_err  out  1 each     sticky overflow / underflow flags
// BEHAVIOUR
//  Reset: all outputs 0 except buf_wr_ready=1; both banks empty; banks 0/0; modes off.
//  Commands: applied only when command_flag=1.
//   - ctrl=4'b0100: value 0 -> pend_mirror=0; value 1 -> pend_mirror=1; other values ignored.
//   - ctrl=4'b0101: pend_blank=value[0].
//   - Pending modes copy to active modes only on frame_start, so there is no mid-frame tearing.
//  Write side:
//   - buf_wr_ready = !full[wr_bank].
//   - buf_wr_en & ready -> store beat at wr_beat in wr_bank; wr_beat++.
//   - On beat BPL-1: set full[wr_bank], toggle wr_bank, wr_beat=0.
//   - buf_wr_en & !ready -> beat dropped, ovf_err=1.
//  Read side (states IDLE/ACTIVE):
//   - IDLE: a cycle with rd_en and full[rd_bank] enters ACTIVE with pix_cnt=0; that pixel is served.
//   - Pixel address a = mirror ? H_WIDTH-1-pix_cnt : pix_cnt; beat = a/PPB, lane = a%PPB.
//   - Registered read: rgb_out and de_o are valid 1 cycle after rd_en.
//   - Each rd_en increments pix_cnt. Gaps in rd_en hold state.
//   - Pixel H_WIDTH-1 served: clear full[rd_bank], toggle rd_bank, row_count++ (wraps H_HEIGHT-1 -> 0), return to IDLE.
//   - rd_en with rd_bank empty: de_o=1, rgb_out=0, unf_err=1, no counter change.
//   - Blank: blank_en & pix_cnt>=BLANK_X0 & row_count>=BLANK_Y0 -> rgb_out=0. Counters use the unmirrored pix_cnt.
//  Same cycle write-completes and read-frees the other bank: both take effect; no conflict.
//  Same bank last write and first read in one cycle: the read sees empty (full updates next cycle).
//  frame_start (highest priority):
//   - Empties both banks, zeroes wr_beat, pix_cnt, row_count and both bank pointers; returns to IDLE.
//   - Writes and reads in that same cycle are discarded; no error flags are set.
//   - Advances frame counter 1->2->3->4->1; frame_instruct updates one cycle later.
//  Error flags clear only on rst.
//  rst asserted mid-line: immediate return to the reset state; a partly written line is lost.
// TESTING
//  1 Defaults, mirror=0, write 80 beats with pixel value=index 0..1279, 1280 rd_en -> rgb_out 0..1279, de_o lags rd_en by 1.
//  2 Mirror command value 1 then frame_start, same line -> rgb_out 1279 down to 0; command without frame_start -> still forward.
//  3 Blank on (ctrl 0101 value 1), rows 179 and 180 read -> row 179 intact; row 180 pixels 960..1279 = 0, 0..959 intact.
//  4 Write 160 beats, no reads -> buf_wr_ready=0 after beat 160; 161st beat dropped, ovf_err=1; one line read -> ready=1.
//  5 rd_en with empty banks -> de_o=1, rgb_out=0, unf_err=1, row_count unchanged.
//  6 frame_start mid-line (pixel 500) and rst mid-write -> counters/banks cleared; row_count=0; 4 frame_starts cycle frame_instruct 0,0,1,1.

Source files
------------

// File: rtl/ddr_line_mirror_buf_if.sv
// ddr_line_mirror_buf_if
// Bus bundle between the DDR read path / HDMI timing logic and the ping-pong line buffer.
// Ports (all signals; clk/rst are plain module ports):
//   frame_start       1-cycle pulse at start of each output frame
//   ctrl_command_in   command class, value_command_in command value, command_flag valid strobe
//   buf_wr_en/_data   one wide DDR beat per cycle, buf_wr_ready = current write bank free
//   rd_en             request one output pixel, de_o/rgb_out the pixel one cycle later
//   row_count         current output row, frame_instruct 4-frame cycle phase
//   ovf_err/unf_err   sticky overflow / underflow flags
// The master modport is the side that feeds the buffer, the slave modport is the buffer.
`timescale 1ns/1ps
interface ddr_line_mirror_buf_if #(
  parameter int BW        = 256,
  parameter int PIX_WIDTH = 16
);
  logic                 frame_start;
  logic [3:0]           ctrl_command_in;
  logic [3:0]           value_command_in;
  logic                 command_flag;
  logic                 buf_wr_en;
  logic [BW-1:0]        buf_wr_data;
  logic                 buf_wr_ready;
  logic                 rd_en;
  logic                 de_o;
  logic [PIX_WIDTH-1:0] rgb_out;
  logic [10:0]          row_count;
  logic                 frame_instruct;
  logic                 ovf_err;
  logic                 unf_err;

  modport master (
    output frame_start, ctrl_command_in, value_command_in, command_flag,
    output buf_wr_en, buf_wr_data, rd_en,
    input  buf_wr_ready, de_o, rgb_out, row_count, frame_instruct, ovf_err, unf_err
  );

  modport slave (
    input  frame_start, ctrl_command_in, value_command_in, command_flag,
    input  buf_wr_en, buf_wr_data, rd_en,
    output buf_wr_ready, de_o, rgb_out, row_count, frame_instruct, ovf_err, unf_err
  );
endinterface

// File: rtl/ddr_line_mirror_buf.sv
// ddr_line_mirror_buf
// Single-clock ping-pong line buffer between the DDR read path and the HDMI pixel path.
// Two banks each hold one full line of wide DDR beats; a line is replayed one pixel per
// rd_en in forward or horizontally mirrored order, with an optional blanking window in
// the lower-right corner of the frame. Mode changes only take effect on frame_start.
// Ports:
//   clk   single clock for all logic
//   rst   asynchronous reset, active-high
//   bus   ddr_line_mirror_buf_if.slave (commands, beat write port, pixel read port, status)
`timescale 1ns/1ps
module ddr_line_mirror_buf #(
  parameter int DQ_WIDTH  = 32,
  parameter int PIX_WIDTH = 16,
  parameter int H_WIDTH   = 1280,
  parameter int H_HEIGHT  = 720,
  parameter int BLANK_X0  = 960,
  parameter int BLANK_Y0  = 180
) (
  input logic                clk,
  input logic                rst,
  ddr_line_mirror_buf_if.slave bus
);

  localparam int BW  = DQ_WIDTH * 8;
  localparam int PPB = BW / PIX_WIDTH;
  localparam int BPL = H_WIDTH / PPB;
  localparam int PCW = $clog2(H_WIDTH);
  localparam int BCW = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int LW  = (PPB > 1) ? $clog2(PPB) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } rd_state_e;

  rd_state_e            state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [BCW-1:0]       wr_beat_q, wr_beat_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [PCW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [10:0]          row_q, row_d;
  logic                 de_q, de_d;
  logic [PIX_WIDTH-1:0] rgb_q, rgb_d;
  logic [2:0]           frame_cnt_q, frame_cnt_d;
  logic                 frame_instr_q, frame_instr_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 pend_mirror_q, pend_mirror_d;
  logic                 pend_blank_q, pend_blank_d;
  logic                 mirror_q, mirror_d;
  logic                 blank_q, blank_d;

  // Line storage: deliberately not reset, contents are only meaningful behind full_q.
  logic [BW-1:0]        mem_q [2][BPL];
  logic                 mem_we;

  logic [PCW-1:0]       cur_pix;
  logic [PCW-1:0]       pix_addr;
  logic [BCW-1:0]       rd_beat;
  logic [LW-1:0]        rd_lane;
  logic [BW-1:0]        rd_word;
  logic [PIX_WIDTH-1:0] rd_pix;
  logic                 blank_hit;

  assign bus.buf_wr_ready   = !full_q[wr_bank_q];
  assign bus.de_o           = de_q;
  assign bus.rgb_out        = rgb_q;
  assign bus.row_count      = row_q;
  assign bus.frame_instruct = frame_instr_q;
  assign bus.ovf_err        = ovf_q;
  assign bus.unf_err        = unf_q;

  // Pixel addressing. A fresh line always starts at pixel 0 when leaving IDLE; the
  // mirror only changes which stored pixel is fetched, while blanking and end-of-line
  // detection use the unmirrored output position.
  always_comb begin
    cur_pix   = (state_q == ST_IDLE) ? '0 : pix_cnt_q;
    pix_addr  = mirror_q ? (PCW'(H_WIDTH - 1) - cur_pix) : cur_pix;
    rd_beat   = BCW'(pix_addr / PCW'(PPB));
    rd_lane   = LW'(pix_addr % PCW'(PPB));
    rd_word   = mem_q[rd_bank_q][rd_beat];
    rd_pix    = rd_word[rd_lane*PIX_WIDTH +: PIX_WIDTH];
    blank_hit = blank_q && (cur_pix >= PCW'(BLANK_X0)) && (row_q >= 11'(BLANK_Y0));
  end

  // Next-state logic. frame_start overrides everything on the data path: both banks are
  // emptied, pointers rewind, and any write or read in that cycle is silently discarded.
  always_comb begin
    state_d       = state_q;
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    wr_beat_d     = wr_beat_q;
    rd_bank_d     = rd_bank_q;
    pix_cnt_d     = pix_cnt_q;
    row_d         = row_q;
    de_d          = 1'b0;
    rgb_d         = '0;
    frame_cnt_d   = frame_cnt_q;
    frame_instr_d = (frame_cnt_q >= 3'd3);
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    pend_mirror_d = pend_mirror_q;
    pend_blank_d  = pend_blank_q;
    mirror_d      = mirror_q;
    blank_d       = blank_q;
    mem_we        = 1'b0;

    if (bus.command_flag) begin
      if (bus.ctrl_command_in == 4'b0100) begin
        if (bus.value_command_in == 4'd0) begin
          pend_mirror_d = 1'b0;
        end else if (bus.value_command_in == 4'd1) begin
          pend_mirror_d = 1'b1;
        end
      end else if (bus.ctrl_command_in == 4'b0101) begin
        pend_blank_d = bus.value_command_in[0];
      end
    end

    if (bus.frame_start) begin
      state_d     = ST_IDLE;
      full_d      = 2'b00;
      wr_bank_d   = 1'b0;
      wr_beat_d   = '0;
      rd_bank_d   = 1'b0;
      pix_cnt_d   = '0;
      row_d       = '0;
      mirror_d    = pend_mirror_q;
      blank_d     = pend_blank_q;
      frame_cnt_d = (frame_cnt_q == 3'd4) ? 3'd1 : frame_cnt_q + 3'd1;
    end else begin
      if (bus.buf_wr_en) begin
        if (!full_q[wr_bank_q]) begin
          mem_we = 1'b1;
          if (wr_beat_q == BCW'(BPL - 1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_beat_d         = '0;
          end else begin
            wr_beat_d = wr_beat_q + 1'b1;
          end
        end else begin
          ovf_d = 1'b1;
        end
      end

      // Reads look at full_q, so a bank completed by a write in this same cycle is still
      // seen as empty here; the two banks never collide because a bank is either being
      // written (empty) or being read (full).
      if (bus.rd_en) begin
        de_d = 1'b1;
        if (full_q[rd_bank_q]) begin
          rgb_d = blank_hit ? '0 : rd_pix;
          if (cur_pix == PCW'(H_WIDTH - 1)) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            row_d             = (row_q == 11'(H_HEIGHT - 1)) ? '0 : row_q + 11'd1;
            pix_cnt_d         = '0;
            state_d           = ST_IDLE;
          end else begin
            pix_cnt_d = cur_pix + 1'b1;
            state_d   = ST_ACTIVE;
          end
        end else begin
          unf_d = 1'b1;
        end
      end
    end
  end

  // State register, everything returns to the empty/idle condition on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      full_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      wr_beat_q     <= '0;
      rd_bank_q     <= 1'b0;
      pix_cnt_q     <= '0;
      row_q         <= '0;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_cnt_q   <= 3'd0;
      frame_instr_q <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      pend_mirror_q <= 1'b0;
      pend_blank_q  <= 1'b0;
      mirror_q      <= 1'b0;
      blank_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      wr_beat_q     <= wr_beat_d;
      rd_bank_q     <= rd_bank_d;
      pix_cnt_q     <= pix_cnt_d;
      row_q         <= row_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_instr_q <= frame_instr_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      pend_mirror_q <= pend_mirror_d;
      pend_blank_q  <= pend_blank_d;
      mirror_q      <= mirror_d;
      blank_q       <= blank_d;
    end
  end

  // Beat storage write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_bank_q][wr_beat_q] <= bus.buf_wr_data;
    end
  end

endmodule

// File: tb/tb_ddr_line_mirror_buf.sv
`timescale 1ns/1ps
module tb_ddr_line_mirror_buf;

  // Frame height and blank row are shrunk so that the blank boundary and the row wrap
  // can be reached in a few thousand cycles; line geometry stays at the defaults.
  localparam int TB_H_HEIGHT = 8;
  localparam int TB_BLANK_Y0 = 4;
  localparam int TB_H        = 1280;
  localparam int TB_BPL      = 80;
  localparam int TB_BLANK_X0 = 960;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   exp_row = 0;

  always #5 clk = ~clk;

  ddr_line_mirror_buf_if #(.BW(256), .PIX_WIDTH(16)) bus ();

  ddr_line_mirror_buf #(
    .H_HEIGHT(TB_H_HEIGHT),
    .BLANK_Y0(TB_BLANK_Y0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make_beat(input logic [15:0] base, input int b);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = base + 16'(b*16 + k);
    return w;
  endfunction

  task automatic write_beats(input logic [15:0] base, input int first, input int count);
    for (int b = first; b < first + count; b++) begin
      bus.buf_wr_en   = 1'b1;
      bus.buf_wr_data = make_beat(base, b);
      tick();
    end
    bus.buf_wr_en = 1'b0;
  endtask

  task automatic send_command(input logic [3:0] ctrl, input logic [3:0] val);
    bus.ctrl_command_in  = ctrl;
    bus.value_command_in = val;
    bus.command_flag     = 1'b1;
    tick();
    bus.command_flag = 1'b0;
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // Replays a whole line with a one-cycle rd_en gap every 400 pixels and counts pixels
  // that disagree with the expected forward/mirrored/blanked value.
  task automatic read_line(input logic [15:0] base, input bit mirror, input bit blank,
                           output int errs, output int first_bad);
    logic [15:0] exp_pix;
    errs = 0;
    first_bad = -1;
    for (int i = 0; i < TB_H; i++) begin
      if (i % 400 == 399) begin
        bus.rd_en = 1'b0;
        tick();
        if (bus.de_o !== 1'b0) begin
          errs++;
          if (first_bad < 0) first_bad = i;
        end
      end
      bus.rd_en = 1'b1;
      tick();
      exp_pix = mirror ? base + 16'(TB_H - 1 - i) : base + 16'(i);
      if (blank && i >= TB_BLANK_X0) exp_pix = 16'h0000;
      if (bus.de_o !== 1'b1 || bus.rgb_out !== exp_pix) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.buf_wr_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %0b expected 1", bus.buf_wr_ready); else passes++;
    checks++; if (bus.de_o !== 1'b0) $display("[TB] FAIL reset_de_o: got %0b expected 0", bus.de_o); else passes++;
    checks++; if (bus.rgb_out !== 16'h0) $display("[TB] FAIL reset_rgb: got %0h expected 0", bus.rgb_out); else passes++;
    checks++; if (bus.row_count !== 11'd0) $display("[TB] FAIL reset_row: got %0d expected 0", bus.row_count); else passes++;
    checks++; if ({bus.frame_instruct, bus.ovf_err, bus.unf_err} !== 3'b000) $display("[TB] FAIL reset_flags: got %03b expected 000", {bus.frame_instruct, bus.ovf_err, bus.unf_err}); else passes++;
    rst = 1'b0;
    tick();
    exp_row = 0;
  endtask

  task automatic test_forward();
    int errs, fb;
    write_beats(16'h0000, 0, TB_BPL);
    read_line(16'h0000, 1'b0, 1'b0, errs, fb);
    checks++; if (errs !== 0) $display("[TB] FAIL forward_line: got %0d bad pixels (first %0d) expected 0", errs, fb); else passes++;
    exp_row = 1;
    tick();
    checks++; if (bus.de_o !== 1'b0) $display("[TB] FAIL forward_de_drop: got %0b expected 0", bus.de_o); else passes++;
    checks++; if (bus.row_count !== 11'(exp_row)) $display("[TB] FAIL forward_row: got %0d expected %0d", bus.row_count, exp_row); else passes++;
  endtask

  task automatic test_mirror();
    int errs, fb;
    send_command(4'b0100, 4'd1);
    write_beats(16'h1000, 0, TB_BPL);
    read_line(16'h1000, 1'b0, 1'b0, errs, fb);
    checks++; if (errs !== 0) $display("[TB] FAIL mirror_pending_forward: got %0d bad pixels (first %0d) expected 0", errs, fb); else passes++;
    send_command(4'b0100, 4'd2);
    pulse_frame_start();
    exp_row = 0;
    checks++; if (bus.row_count !== 11'd0) $display("[TB] FAIL mirror_frame_row: got %0d expected 0", bus.row_count); else passes++;
    write_beats(16'h2000, 0, TB_BPL);
    read_line(16'h2000, 1'b1, 1'b0, errs, fb);
    checks++; if (errs !== 0) $display("[TB] FAIL mirror_line: got %0d bad pixels (first %0d) expected 0", errs, fb); else passes++;
    exp_row = 1;
  endtask

  task automatic test_blank_wrap();
    int errs, fb;
    logic [15:0] base;
    send_command(4'b0100, 4'd0);
    send_command(4'b0101, 4'd1);
    pulse_frame_start();
    exp_row = 0;
    for (int r = 0; r < TB_H_HEIGHT; r++) begin
      base = 16'h4000 + 16'(r * 16'h0800);
      write_beats(base, 0, TB_BPL);
      read_line(base, 1'b0, (r >= TB_BLANK_Y0), errs, fb);
      checks++; if (errs !== 0) $display("[TB] FAIL blank_row%0d: got %0d bad pixels (first %0d) expected 0", r, errs, fb); else passes++;
    end
    exp_row = 0;
    checks++; if (bus.row_count !== 11'd0) $display("[TB] FAIL row_wrap: got %0d expected 0", bus.row_count); else passes++;
  endtask

  task automatic test_overflow();
    int errs, fb;
    write_beats(16'h8000, 0, TB_BPL);
    write_beats(16'h9000, 0, TB_BPL);
    checks++; if (bus.buf_wr_ready !== 1'b0) $display("[TB] FAIL ovf_ready_full: got %0b expected 0", bus.buf_wr_ready); else passes++;
    checks++; if (bus.ovf_err !== 1'b0) $display("[TB] FAIL ovf_not_yet: got %0b expected 0", bus.ovf_err); else passes++;
    write_beats(16'hEEEE, 0, 1);
    checks++; if (bus.ovf_err !== 1'b1) $display("[TB] FAIL ovf_set: got %0b expected 1", bus.ovf_err); else passes++;
    read_line(16'h8000, 1'b0, 1'b0, errs, fb);
    checks++; if (errs !== 0) $display("[TB] FAIL ovf_line_a: got %0d bad pixels (first %0d) expected 0", errs, fb); else passes++;
    checks++; if (bus.buf_wr_ready !== 1'b1) $display("[TB] FAIL ovf_ready_free: got %0b expected 1", bus.buf_wr_ready); else passes++;
    read_line(16'h9000, 1'b0, 1'b0, errs, fb);
    checks++; if (errs !== 0) $display("[TB] FAIL ovf_line_b: got %0d bad pixels (first %0d) expected 0", errs, fb); else passes++;
    exp_row = 2;
  endtask

  task automatic test_underflow();
    checks++; if (bus.unf_err !== 1'b0) $display("[TB] FAIL unf_not_yet: got %0b expected 0", bus.unf_err); else passes++;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if ({bus.de_o, bus.unf_err} !== 2'b11) $display("[TB] FAIL unf_de_flag: got %02b expected 11", {bus.de_o, bus.unf_err}); else passes++;
    checks++; if (bus.rgb_out !== 16'h0) $display("[TB] FAIL unf_rgb: got %0h expected 0", bus.rgb_out); else passes++;
    checks++; if (bus.row_count !== 11'(exp_row)) $display("[TB] FAIL unf_row: got %0d expected %0d", bus.row_count, exp_row); else passes++;
    tick();
    checks++; if (bus.de_o !== 1'b0) $display("[TB] FAIL unf_de_drop: got %0b expected 0", bus.de_o); else passes++;
    // Last beat of a bank and first read of that same bank in one cycle.
    write_beats(16'hA000, 0, TB_BPL - 1);
    bus.buf_wr_en   = 1'b1;
    bus.buf_wr_data = make_beat(16'hA000, TB_BPL - 1);
    bus.rd_en       = 1'b1;
    tick();
    bus.buf_wr_en = 1'b0;
    checks++; if ({bus.de_o, bus.rgb_out} !== {1'b1, 16'h0}) $display("[TB] FAIL race_empty: got %0b/%0h expected 1/0", bus.de_o, bus.rgb_out); else passes++;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.rgb_out !== 16'hA000) $display("[TB] FAIL race_next_pixel: got %0h expected a000", bus.rgb_out); else passes++;
  endtask

  task automatic test_frame_start();
    int errs, fb;
    write_beats(16'h5000, 0, 40);
    rst = 1'b1;
    tick();
    checks++; if ({bus.buf_wr_ready, bus.ovf_err, bus.unf_err, bus.de_o} !== 4'b1000) $display("[TB] FAIL rst_mid_state: got %04b expected 1000", {bus.buf_wr_ready, bus.ovf_err, bus.unf_err, bus.de_o}); else passes++;
    checks++; if (bus.row_count !== 11'd0) $display("[TB] FAIL rst_mid_row: got %0d expected 0", bus.row_count); else passes++;
    rst = 1'b0;
    tick();
    exp_row = 0;
    write_beats(16'h6000, 0, TB_BPL);
    write_beats(16'h6800, 0, TB_BPL);
    for (int i = 0; i < 500; i++) begin
      bus.rd_en = 1'b1;
      tick();
    end
    // Frame 1: arrives mid-line together with a read and a write into a full bank.
    bus.frame_start = 1'b1;
    bus.buf_wr_en   = 1'b1;
    bus.buf_wr_data = make_beat(16'hBBBB, 0);
    tick();
    bus.frame_start = 1'b0;
    bus.buf_wr_en   = 1'b0;
    bus.rd_en       = 1'b0;
    checks++; if ({bus.de_o, bus.ovf_err, bus.unf_err} !== 3'b000) $display("[TB] FAIL fs_discard: got %03b expected 000", {bus.de_o, bus.ovf_err, bus.unf_err}); else passes++;
    checks++; if ({bus.buf_wr_ready, bus.row_count} !== {1'b1, 11'd0}) $display("[TB] FAIL fs_cleared: got %0b/%0d expected 1/0", bus.buf_wr_ready, bus.row_count); else passes++;
    tick();
    checks++; if (bus.frame_instruct !== 1'b0) $display("[TB] FAIL fi_frame1: got %0b expected 0", bus.frame_instruct); else passes++;
    write_beats(16'h7000, 0, TB_BPL);
    read_line(16'h7000, 1'b0, 1'b0, errs, fb);
    checks++; if (errs !== 0) $display("[TB] FAIL fs_fresh_line: got %0d bad pixels (first %0d) expected 0", errs, fb); else passes++;
    // Frame 2: arrives with a read on empty banks, which must not raise underflow.
    bus.rd_en = 1'b1;
    pulse_frame_start();
    bus.rd_en = 1'b0;
    tick();
    checks++; if ({bus.frame_instruct, bus.unf_err} !== 2'b00) $display("[TB] FAIL fi_frame2: got %02b expected 00", {bus.frame_instruct, bus.unf_err}); else passes++;
    pulse_frame_start();
    checks++; if (bus.frame_instruct !== 1'b0) $display("[TB] FAIL fi_frame3_lag: got %0b expected 0", bus.frame_instruct); else passes++;
    tick();
    checks++; if (bus.frame_instruct !== 1'b1) $display("[TB] FAIL fi_frame3: got %0b expected 1", bus.frame_instruct); else passes++;
    pulse_frame_start();
    tick();
    checks++; if (bus.frame_instruct !== 1'b1) $display("[TB] FAIL fi_frame4: got %0b expected 1", bus.frame_instruct); else passes++;
    pulse_frame_start();
    tick();
    checks++; if (bus.frame_instruct !== 1'b0) $display("[TB] FAIL fi_wrap_frame1: got %0b expected 0", bus.frame_instruct); else passes++;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.frame_start      = 1'b0;
    bus.ctrl_command_in  = 4'd0;
    bus.value_command_in = 4'd0;
    bus.command_flag     = 1'b0;
    bus.buf_wr_en        = 1'b0;
    bus.buf_wr_data      = '0;
    bus.rd_en            = 1'b0;
    test_reset();
    test_forward();
    test_mirror();
    test_blank_wrap();
    test_overflow();
    test_underflow();
    test_frame_start();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
